// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Purpose  : Shares one external SRAM/bus port between instruction fetch (IF)
//            and the MEM-stage load/store path. The data side always wins in
//            IDLE. The granted request is registered onto the m_* port and
//            held until the slave acks or the wait counter times out. Read
//            data and a one-cycle ack go back to the owner.
// Ports    : clk, rst           - clock / synchronous active-high reset
//            i_ce, i_addr       - fetch request (held until i_ack)
//            i_rdata, i_ack     - fetch read data / completion pulse
//            d_ce, d_we, d_sel,
//            d_addr, d_wdata    - data request (held until d_ack)
//            d_rdata, d_ack     - load data / completion pulse
//            m_req, m_we, m_sel,
//            m_addr, m_wdata    - registered bus request to the slave
//            m_rdata, m_ack     - slave response
//            stallreq_if/_mem   - combinational stall requests
//            bus_err            - pulse alongside the ack of a timed-out access
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_ce,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    input  logic        d_ce,
    input  logic        d_we,
    input  logic [3:0]  d_sel,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        m_req,
    output logic        m_we,
    output logic [3:0]  m_sel,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    output logic        stallreq_if,
    output logic        stallreq_mem,
    output logic        bus_err
);

    localparam logic [1:0]       c_IDLE    = 2'd0;
    localparam logic [1:0]       c_D_BUSY  = 2'd1;
    localparam logic [1:0]       c_I_BUSY  = 2'd2;
    localparam bit               c_TO_EN   = (TIMEOUT > 0);
    // Counter value seen in the last allowed wait cycle (counter starts at 0
    // in the first m_req cycle).
    localparam logic [CNT_W-1:0] c_TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    logic [1:0]       state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             m_req_q,   m_req_d;
    logic             m_we_q,    m_we_d;
    logic [3:0]       m_sel_q,   m_sel_d;
    logic [31:0]      m_addr_q,  m_addr_d;
    logic [31:0]      m_wdata_q, m_wdata_d;
    logic [31:0]      i_rdata_q, i_rdata_d;
    logic [31:0]      d_rdata_q, d_rdata_d;
    logic             i_ack_q,   i_ack_d;
    logic             d_ack_q,   d_ack_d;
    logic             bus_err_q, bus_err_d;

    logic w_d_new;
    logic w_i_new;
    logic w_turn;
    logic w_busy;
    logic w_to;
    logic w_done;

    // A ce that is still high during its own ack pulse is the tail of the
    // finished request, not a new one.
    assign w_d_new = d_ce & ~d_ack_q;
    assign w_i_new = i_ce & ~i_ack_q;
    // The ack cycle is a bus turnaround: no grant is made while any ack is
    // out, giving one idle cycle between an ack and the next m_req.
    assign w_turn  = i_ack_q | d_ack_q;
    assign w_busy  = (state_q != c_IDLE);
    // m_ack at the same edge as the timeout wins.
    assign w_to    = c_TO_EN && w_busy && !m_ack && (cnt_q == c_TO_LAST);
    assign w_done  = w_busy && (m_ack || w_to);

    // ------------------------------------------------------------------
    // State register (all flops)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= c_IDLE;
            cnt_q     <= '0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_sel_q   <= 4'h0;
            m_addr_q  <= 32'h0;
            m_wdata_q <= 32'h0;
            i_rdata_q <= 32'h0;
            d_rdata_q <= 32'h0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_sel_q   <= m_sel_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            bus_err_q <= bus_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE: begin
                if (!w_turn) begin
                    if (w_d_new)      state_d = c_D_BUSY;
                    else if (w_i_new) state_d = c_I_BUSY;
                end
            end
            c_D_BUSY, c_I_BUSY: begin
                if (w_done) state_d = c_IDLE;
            end
            default: state_d = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d     = cnt_q;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_sel_d   = m_sel_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        bus_err_d = 1'b0;
        case (state_q)
            c_IDLE: begin
                cnt_d = '0;
                if (!w_turn) begin
                    if (w_d_new) begin
                        m_req_d   = 1'b1;
                        m_we_d    = d_we;
                        m_sel_d   = d_sel;
                        m_addr_d  = d_addr;
                        m_wdata_d = d_wdata;
                    end else if (w_i_new) begin
                        m_req_d   = 1'b1;
                        m_we_d    = 1'b0;
                        m_sel_d   = 4'hF;
                        m_addr_d  = i_addr;
                        m_wdata_d = 32'h0;
                    end
                end
            end
            c_D_BUSY: begin
                if (w_done) begin
                    m_req_d = 1'b0;
                    m_we_d  = 1'b0;
                    cnt_d   = '0;
                    // A dropped d_ce means the pipeline abandoned the access:
                    // the bus cycle finishes but nothing is returned.
                    if (d_ce) begin
                        d_ack_d   = 1'b1;
                        bus_err_d = w_to;
                        if (!m_we_q) d_rdata_d = w_to ? 32'h0 : m_rdata;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            c_I_BUSY: begin
                if (w_done) begin
                    m_req_d = 1'b0;
                    m_we_d  = 1'b0;
                    cnt_d   = '0;
                    if (i_ce) begin
                        i_ack_d   = 1'b1;
                        bus_err_d = w_to;
                        i_rdata_d = w_to ? 32'h0 : m_rdata;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    assign m_req        = m_req_q;
    assign m_we         = m_we_q;
    assign m_sel        = m_sel_q;
    assign m_addr       = m_addr_q;
    assign m_wdata      = m_wdata_q;
    assign i_rdata      = i_rdata_q;
    assign d_rdata      = d_rdata_q;
    assign i_ack        = i_ack_q;
    assign d_ack        = d_ack_q;
    assign bus_err      = bus_err_q;
    assign stallreq_if  = i_ce & ~i_ack_q;
    assign stallreq_mem = d_ce & ~d_ack_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Purpose  : Self-checking bench for mem_bus_arbiter. A transaction-level
//            model predicts every output each cycle; directed scenarios add
//            hand-computed latency/data expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_ce = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        d_ce = 1'b0;
    logic        d_we = 1'b0;
    logic [3:0]  d_sel = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        m_req;
    logic        m_we;
    logic [3:0]  m_sel;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata = '0;
    logic        m_ack = 1'b0;
    logic        stallreq_if;
    logic        stallreq_mem;
    logic        bus_err;

    mem_bus_arbiter #(.TIMEOUT(TMO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .i_ce(i_ce), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_ce(d_ce), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
        .m_req(m_req), .m_we(m_we), .m_sel(m_sel), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack(m_ack),
        .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- slave: acks after sl_wait wait states ----------------
    int          sl_wait = 0;
    int          sl_cnt  = 0;
    logic [31:0] sl_data = '0;

    always @(negedge clk) begin
        if (m_req === 1'b1) begin
            m_ack   = (sl_cnt == sl_wait);
            m_rdata = m_ack ? sl_data : 32'hA5A5A5A5;
            sl_cnt++;
        end else begin
            m_ack   = 1'b0;
            m_rdata = 32'h5A5A5A5A;
            sl_cnt  = 0;
        end
    end

    // ---------------- transaction-level model ----------------
    // owner: 0 = bus free, 1 = data, 2 = fetch; age = m_req cycles so far.
    int          owner = 0;
    int          age   = 0;
    logic        e_req = 0, e_we = 0, e_iack = 0, e_dack = 0, e_err = 0;
    logic [3:0]  e_sel = '0;
    logic [31:0] e_addr = '0, e_wdata = '0, e_irdata = '0, e_drdata = '0;
    logic        was_ack, timed_out, own_ce, was_we;

    always @(posedge clk) begin
        if (rst) begin
            owner = 0; age = 0;
            e_req = 0; e_we = 0; e_iack = 0; e_dack = 0; e_err = 0;
            e_sel = '0; e_addr = '0; e_wdata = '0; e_irdata = '0; e_drdata = '0;
        end else begin
            was_ack = e_iack | e_dack;
            e_iack = 0; e_dack = 0; e_err = 0;
            if (owner == 0) begin
                if (!was_ack) begin
                    if (d_ce) begin
                        owner = 1; age = 1; e_req = 1;
                        e_we = d_we; e_sel = d_sel; e_addr = d_addr; e_wdata = d_wdata;
                    end else if (i_ce) begin
                        owner = 2; age = 1; e_req = 1;
                        e_we = 0; e_sel = 4'hF; e_addr = i_addr; e_wdata = 0;
                    end
                end
            end else if (m_ack || age == TMO) begin
                timed_out = !m_ack;
                own_ce    = (owner == 1) ? d_ce : i_ce;
                was_we    = e_we;
                if (own_ce) begin
                    e_err = timed_out;
                    if (owner == 1) begin
                        e_dack = 1;
                        if (!was_we) e_drdata = timed_out ? 32'h0 : m_rdata;
                    end else begin
                        e_iack = 1;
                        e_irdata = timed_out ? 32'h0 : m_rdata;
                    end
                end
                e_req = 0; e_we = 0; owner = 0; age = 0;
            end else begin
                age++;
            end
        end
    end

    // ---------------- compare + event monitor ----------------
    int          n_mreq = 0, d_ack_n = 0, i_ack_n = 0, err_n = 0;
    int          d_ack_cyc = -1, i_ack_cyc = -1, err_cyc = -1, start_cyc = -1;
    logic        prev_req = 0;
    logic        stab_bad = 0;
    logic [31:0] st_addr_q[$];
    logic        st_we_q[$];
    logic [3:0]  st_sel_q[$];
    logic [31:0] h_addr = '0, h_wdata = '0;
    logic [3:0]  h_sel = '0;
    logic        h_we = 0;

    always @(posedge clk) begin
        #1;
        chk("m_req",        32'(m_req),        32'(e_req));
        chk("m_we",         32'(m_we),         32'(e_we));
        chk("m_sel",        32'(m_sel),        32'(e_sel));
        chk("m_addr",       m_addr,            e_addr);
        chk("m_wdata",      m_wdata,           e_wdata);
        chk("i_rdata",      i_rdata,           e_irdata);
        chk("d_rdata",      d_rdata,           e_drdata);
        chk("i_ack",        32'(i_ack),        32'(e_iack));
        chk("d_ack",        32'(d_ack),        32'(e_dack));
        chk("bus_err",      32'(bus_err),      32'(e_err));
        chk("stallreq_if",  32'(stallreq_if),  32'(i_ce & ~e_iack));
        chk("stallreq_mem", 32'(stallreq_mem), 32'(d_ce & ~e_dack));
        if (m_req) begin
            n_mreq++;
            if (!prev_req) begin
                start_cyc = cyc;
                st_addr_q.push_back(m_addr);
                st_we_q.push_back(m_we);
                st_sel_q.push_back(m_sel);
                h_addr = m_addr; h_wdata = m_wdata; h_sel = m_sel; h_we = m_we;
            end else if (m_addr != h_addr || m_wdata != h_wdata || m_sel != h_sel || m_we != h_we) begin
                stab_bad = 1;
            end
        end
        prev_req = m_req;
        if (d_ack)   begin d_ack_n++; d_ack_cyc = cyc; end
        if (i_ack)   begin i_ack_n++; i_ack_cyc = cyc; end
        if (bus_err) begin err_n++;   err_cyc   = cyc; end
    end

    task automatic clr_mon();
        n_mreq = 0; d_ack_n = 0; i_ack_n = 0; err_n = 0;
        d_ack_cyc = -1; i_ack_cyc = -1; err_cyc = -1; start_cyc = -1;
        stab_bad = 0;
        st_addr_q.delete(); st_we_q.delete(); st_sel_q.delete();
    endtask

    // Waits (bounded) at negedges until the selected ack is seen.
    task automatic wait_ack(input bit is_d, input string nm);
        int k;
        k = 0;
        while (!(is_d ? d_ack : i_ack) && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk(nm, 32'(is_d ? d_ack : i_ack), 32'd1);
    endtask

    task automatic d_req(input logic we, input logic [3:0] sel,
                         input logic [31:0] addr, input logic [31:0] wdata);
        d_ce = 1; d_we = we; d_sel = sel; d_addr = addr; d_wdata = wdata;
    endtask

    int c0;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_m_req",   32'(m_req),   32'd0);
        chk("rst_m_addr",  m_addr,       32'd0);
        chk("rst_d_rdata", d_rdata,      32'd0);
        chk("rst_d_ack",   32'(d_ack),   32'd0);
        rst = 0;
        repeat (2) @(negedge clk);

        // ---- data read, zero wait states ----
        clr_mon(); c0 = cyc;
        sl_wait = 0; sl_data = 32'hDEADBEEF;
        d_req(0, 4'hF, 32'h100, 32'h0);
        wait_ack(1, "rd_wait");
        d_ce = 0;
        chk("rd_latency", 32'(d_ack_cyc - c0), 32'd2);
        chk("rd_data",    d_rdata,             32'hDEADBEEF);
        chk("rd_mreq_n",  32'(n_mreq),         32'd1);
        repeat (3) @(negedge clk);
        chk("rd_ack_n",   32'(d_ack_n),        32'd1);

        // ---- simultaneous requests: data first ----
        clr_mon(); c0 = cyc;
        sl_wait = 0; sl_data = 32'h12345678;
        i_ce = 1; i_addr = 32'h40;
        d_req(0, 4'hF, 32'h200, 32'h0);
        wait_ack(1, "sim_d_wait");
        d_ce = 0;
        wait_ack(0, "sim_i_wait");
        i_ce = 0;
        chk("sim_first_addr",  st_addr_q[0],              32'h200);
        chk("sim_second_addr", st_addr_q[1],              32'h40);
        chk("sim_second_sel",  32'(st_sel_q[1]),          32'hF);
        chk("sim_second_we",   32'(st_we_q[1]),           32'd0);
        chk("sim_ack_gap",     32'(i_ack_cyc - d_ack_cyc), 32'd3);
        chk("sim_i_rdata",     i_rdata,                   32'h12345678);
        repeat (3) @(negedge clk);

        // ---- byte store with 3 wait states ----
        clr_mon(); c0 = cyc;
        sl_wait = 3; sl_data = 32'hFFFFFFFF;
        d_req(1, 4'b0100, 32'h300, 32'h55555555);
        wait_ack(1, "st_wait");
        d_ce = 0; d_we = 0;
        chk("st_mreq_n",   32'(n_mreq),      32'd4);
        chk("st_stable",   32'(stab_bad),    32'd0);
        chk("st_sel",      32'(st_sel_q[0]), 32'h4);
        chk("st_we",       32'(st_we_q[0]),  32'd1);
        chk("st_latency",  32'(d_ack_cyc - c0), 32'd5);
        chk("st_d_rdata",  d_rdata,          32'h12345678);
        repeat (3) @(negedge clk);
        chk("st_ack_n",    32'(d_ack_n),     32'd1);

        // ---- timeout: slave never acks ----
        clr_mon(); c0 = cyc;
        sl_wait = 99;
        d_req(0, 4'hF, 32'h400, 32'h0);
        wait_ack(1, "to_wait");
        d_ce = 0;
        chk("to_mreq_n",  32'(n_mreq),              32'd4);
        chk("to_err_n",   32'(err_n),               32'd1);
        chk("to_err_cyc", 32'(err_cyc - d_ack_cyc), 32'd0);
        chk("to_rdata",   d_rdata,                  32'h0);
        chk("to_latency", 32'(d_ack_cyc - c0),      32'd5);
        repeat (3) @(negedge clk);

        // ---- ack on the last allowed cycle beats the timeout ----
        clr_mon(); c0 = cyc;
        sl_wait = 3; sl_data = 32'hCAFEF00D;
        d_req(0, 4'hF, 32'h404, 32'h0);
        wait_ack(1, "late_wait");
        d_ce = 0;
        chk("late_err_n", 32'(err_n),  32'd0);
        chk("late_rdata", d_rdata,     32'hCAFEF00D);
        chk("late_mreq",  32'(n_mreq), 32'd4);
        repeat (3) @(negedge clk);

        // ---- flushed fetch with data pending ----
        clr_mon(); c0 = cyc;
        sl_wait = 2; sl_data = 32'hBAD0BAD0;
        i_ce = 1; i_addr = 32'h80;
        @(negedge clk);
        d_req(0, 4'hF, 32'h500, 32'h0);
        @(negedge clk);
        i_ce = 0;
        wait_ack(1, "fl_d_wait");
        d_ce = 0;
        chk("fl_i_ack_n",  32'(i_ack_n),        32'd0);
        chk("fl_i_rdata",  i_rdata,             32'h12345678);
        chk("fl_d_addr",   st_addr_q[1],        32'h500);
        chk("fl_d_start",  32'(start_cyc - c0), 32'd5);
        chk("fl_d_ack",    32'(d_ack_cyc - c0), 32'd8);
        chk("fl_d_rdata",  d_rdata,             32'hBAD0BAD0);
        repeat (3) @(negedge clk);

        // ---- reset in the middle of a data access ----
        clr_mon(); c0 = cyc;
        sl_wait = 99;
        d_req(0, 4'hF, 32'h600, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1; d_ce = 0;
        @(negedge clk);
        rst = 0;
        chk("mr_m_req",   32'(m_req),   32'd0);
        chk("mr_m_addr",  m_addr,       32'd0);
        chk("mr_i_rdata", i_rdata,      32'd0);
        chk("mr_d_rdata", d_rdata,      32'd0);
        chk("mr_ack_n",   32'(d_ack_n), 32'd0);
        @(negedge clk);
        c0 = cyc;
        sl_wait = 0; sl_data = 32'h0F0F0F0F;
        d_req(0, 4'hF, 32'h700, 32'h0);
        wait_ack(1, "mr_wait");
        d_ce = 0;
        chk("mr_latency", 32'(d_ack_cyc - c0), 32'd2);
        chk("mr_rdata",   d_rdata,             32'h0F0F0F0F);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
